chacha_block_sched: RTL

- Sequences one external ChaCha quarter-round datapath over a full 16-word (512-bit) ChaCha state to produce one keystream block.
- Accepts the initial state word-serially with a valid/ready handshake.
- Runs DOUBLE_ROUNDS column+diagonal double rounds, then streams the 16 result words out with a valid/ready handshake.
- Sits between the host byte/word interface and the combinational quarter-round datapath; it owns the state registers, the QR operand muxing and the round schedule.

---
 rtl/chacha_block_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/chacha_block_sched.sv
// ChaCha block scheduler: loads 16 words, drives an external QR datapath, drains results.
// Define CHACHA_FEEDFORWARD_EN to add the input copy bank and output feed-forward.
module chacha_block_sched #(
  parameter int DOUBLE_ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        qr_sel,
  output logic [31:0] qr_a_o,
  output logic [31:0] qr_b_o,
  output logic [31:0] qr_c_o,
  output logic [31:0] qr_d_o,
  input  logic [31:0] qr_a_i,
  input  logic [31:0] qr_b_i,
  input  logic [31:0] qr_c_i,
  input  logic [31:0] qr_d_i
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(DOUBLE_ROUNDS - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [3:0]  step;
  logic [3:0]  rnd;
  logic [31:0] x [16];

  logic [1:0]  slot;
  logic        diag;
  logic [1:0]  ob, oc, od;
  logic [3:0]  ia, ib, ic, id;

  // step[3] picks column/diagonal, step[2:1] the slot, step[0] the QR half
  always_comb begin
    slot = step[2:1];
    diag = step[3];
    ob   = slot + (diag ? 2'd1 : 2'd0);
    oc   = slot + (diag ? 2'd2 : 2'd0);
    od   = slot + (diag ? 2'd3 : 2'd0);
    ia   = {2'b00, slot};
    ib   = {2'b01, ob};
    ic   = {2'b10, oc};
    id   = {2'b11, od};
  end

  assign qr_a_o    = x[ia];
  assign qr_b_o    = x[ib];
  assign qr_c_o    = x[ic];
  assign qr_d_o    = x[id];
  assign qr_sel    = (state == RUN) && step[0];
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD);

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:
        if (in_valid && idx == 4'd15)
          state_nxt = RUN;
      RUN:
        if (step == 4'd15 && rnd == LAST_RND)
          state_nxt = DRAIN;
      DRAIN:
        if (out_ready && idx == 4'd15)
          state_nxt = LOAD;
      default:
        state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      idx   <= 4'd0;
      step  <= 4'd0;
      rnd   <= 4'd0;
      for (int i = 0; i < 16; i++)
        x[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      unique case (state)
        LOAD:
          if (in_valid) begin
            x[idx] <= in_data;
            idx    <= idx + 4'd1;
          end
        RUN: begin
          x[ia] <= qr_a_i;
          x[ib] <= qr_b_i;
          x[ic] <= qr_c_i;
          x[id] <= qr_d_i;
          step  <= step + 4'd1;
          if (step == 4'd15)
            rnd <= (rnd == LAST_RND) ? 4'd0 : rnd + 4'd1;
        end
        DRAIN:
          if (out_ready)
            idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

`ifdef CHACHA_FEEDFORWARD_EN
  logic [31:0] init [16];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        init[i] <= 32'd0;
    end else if (state == LOAD && in_valid) begin
      init[idx] <= in_data;
    end
  end

  assign out_data = x[idx] + init[idx];
`else
  assign out_data = x[idx];
`endif

endmodule
